// File: rtl/uart_receiver.sv
// 8N1 UART receive front end: two-flop input synchroniser, mid-bit sampling FSM,
// and a first-word-fall-through byte FIFO presented as a valid/ready stream.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          uart_rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_error,
  output logic                          overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [PW:0]   FULL_COUNT = (PW + 1)'(FIFO_DEPTH);

  // state   | meaning
  // S_IDLE  | line idle, waiting for a low level
  // S_START | timing to the middle of the start bit
  // S_DATA  | sampling 8 data bits, LSB first
  // S_STOP  | sampling the stop bit, push or flag framing error
  // S_BREAK | line held low after a framing error, wait for high
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t          state, state_d;
  logic            sync_q, rx_s;
  logic [CW-1:0]   cnt, cnt_d;
  logic [2:0]      bit_idx, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            sample, push_req, ferr_d;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            full, push, pop, ovr_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_q <= uart_rx;
      rx_s   <= sync_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= HALF_LOAD;
      bit_idx <= '0;
      shift_q <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      shift_q <= shift_d;
    end
  end

  assign sample = (cnt == '0);

  always_comb begin
    state_d   = state;
    cnt_d     = sample ? BIT_RELOAD : cnt - CW'(1);
    bit_idx_d = bit_idx;
    shift_d   = shift_q;
    push_req  = 1'b0;
    ferr_d    = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_d = HALF_LOAD;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (sample) begin
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_idx == 3'd7) state_d = S_STOP;
          else                 bit_idx_d = bit_idx + 3'd1;
        end
      end
      S_STOP: begin
        if (sample) begin
          if (rx_s) begin
            push_req = 1'b1;
            state_d  = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = cnt;
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A full FIFO still accepts the byte when the head is popped in the same cycle.
  assign pop   = rx_valid & rx_ready;
  assign full  = (rx_count == FULL_COUNT);
  assign push  = push_req & (~full | pop);
  assign ovr_d = push_req & ~push;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= shift_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rx_count    <= '0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= ferr_d;
      overrun     <= ovr_d;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   rx_count <= rx_count + (PW + 1)'(1);
        2'b01:   rx_count <= rx_count - (PW + 1)'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  assign rx_valid = (rx_count != '0);
  assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frame timing, FIFO ordering, overrun,
// framing error, start glitch and async reset abort.
module tb_uart_receiver;
  localparam int C = 16;
  localparam int D = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       uart_rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] rx_count;
  logic       frame_error;
  logic       overrun;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int fe_n = 0;
  int ov_n = 0;
  int ov_cyc = 0;
  int last_t0 = 0;
  int fe0, ov0, t0, s_edge;

  logic [7:0] seq [9] = '{8'h01, 8'h80, 8'h5A, 8'hC3, 8'h7E, 8'h99, 8'h24, 8'hE7, 8'hBD};

  uart_receiver #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clock       (clock),
    .reset       (reset),
    .uart_rx     (uart_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_count    (rx_count),
    .frame_error (frame_error),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (frame_error) fe_n <= fe_n + 1;
    if (overrun) begin
      ov_n   <= ov_n + 1;
      ov_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic to_edge(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Called #1 after an edge; the start bit is captured at the following edge.
  task automatic send_frame(input logic [7:0] b, input int stop_low_bits);
    last_t0 = cyc + 1;
    uart_rx = 1'b0;
    wait_cycles(C);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_cycles(C);
    end
    if (stop_low_bits > 0) begin
      uart_rx = 1'b0;
      wait_cycles(stop_low_bits * C);
    end
    uart_rx = 1'b1;
    wait_cycles(C);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, 32'(rx_valid), 1);
    chk(tag, 32'(rx_data), 32'(exp));
    rx_ready = 1'b1;
    wait_cycles(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_count", 32'(rx_count), 0);
    chk("rst_data", 32'(rx_data), 0);
    chk("rst_ferr", 32'(frame_error), 0);
    chk("rst_ovr", 32'(overrun), 0);
    wait_cycles(1);
    to_edge(3);
    reset = 1'b1;

    // single frame, start captured at edge 100, stop sample at edge 254
    to_edge(99);
    fe0 = fe_n;
    fork
      send_frame(8'hA5, 0);
      begin
        to_edge(253);
        chk("single_pre_valid", 32'(rx_valid), 0);
        to_edge(254);
        chk("single_valid", 32'(rx_valid), 1);
        chk("single_data", 32'(rx_data), 32'h A5);
        chk("single_count", 32'(rx_count), 1);
      end
    join
    rx_ready = 1'b1;
    wait_cycles(1);
    rx_ready = 1'b0;
    chk("single_pop_count", 32'(rx_count), 0);
    chk("single_pop_valid", 32'(rx_valid), 0);

    // back-to-back frames, consumer stalled
    fe0 = fe_n;
    ov0 = ov_n;
    send_frame(8'h00, 0);
    send_frame(8'hFF, 0);
    send_frame(8'h3C, 0);
    wait_cycles(2);
    chk("b2b_count", 32'(rx_count), 3);
    pop_expect("b2b_0", 8'h00);
    pop_expect("b2b_1", 8'hFF);
    pop_expect("b2b_2", 8'h3C);
    chk("b2b_empty", 32'(rx_count), 0);
    chk("b2b_ferr", 32'(fe_n - fe0), 0);
    chk("b2b_ovr", 32'(ov_n - ov0), 0);

    // overrun on the ninth frame
    ov0 = ov_n;
    for (int i = 0; i < 9; i++) send_frame(seq[i], 0);
    wait_cycles(2);
    chk("ovr_count", 32'(rx_count), 8);
    chk("ovr_pulses", 32'(ov_n - ov0), 1);
    chk("ovr_edge", 32'(ov_cyc), 32'(last_t0 + 9 * C + C / 2 + 2));
    for (int i = 0; i < 8; i++) pop_expect("ovr_pop", seq[i]);
    chk("ovr_empty", 32'(rx_count), 0);

    // full FIFO with a pop in the stop-sample cycle
    for (int i = 0; i < 8; i++) send_frame(seq[i], 0);
    ov0 = ov_n;
    t0 = cyc + 1;
    s_edge = t0 + 9 * C + C / 2 + 2;
    fork
      send_frame(seq[8], 0);
      begin
        to_edge(s_edge - 1);
        rx_ready = 1'b1;
        to_edge(s_edge);
        rx_ready = 1'b0;
        chk("fullpop_count", 32'(rx_count), 8);
      end
    join
    wait_cycles(2);
    chk("fullpop_ovr", 32'(ov_n - ov0), 0);
    for (int i = 1; i < 9; i++) pop_expect("fullpop_pop", seq[i]);
    chk("fullpop_empty", 32'(rx_count), 0);

    // framing error with long low stop, then a good frame
    fe0 = fe_n;
    send_frame(8'h55, 3);
    wait_cycles(20);
    chk("ferr_count", 32'(rx_count), 0);
    chk("ferr_pulses", 32'(fe_n - fe0), 1);
    send_frame(8'h12, 0);
    wait_cycles(2);
    chk("ferr_next_count", 32'(rx_count), 1);
    chk("ferr_next_data", 32'(rx_data), 32'h12);
    chk("ferr_pulses_after", 32'(fe_n - fe0), 1);

    // short start glitch yields nothing (0x12 stays at the head)
    uart_rx = 1'b0;
    wait_cycles(4);
    uart_rx = 1'b1;
    wait_cycles(40);
    chk("glitch_count", 32'(rx_count), 1);
    chk("glitch_data", 32'(rx_data), 32'h12);

    // async reset during DATA aborts the frame and empties the FIFO
    fork
      send_frame(8'h77, 0);
      begin
        wait_cycles(3 * C);
        #3 reset = 1'b0;
        #1;
        chk("abort_valid", 32'(rx_valid), 0);
        chk("abort_count", 32'(rx_count), 0);
        chk("abort_data", 32'(rx_data), 0);
      end
    join
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(5);
    chk("abort_after_count", 32'(rx_count), 0);
    send_frame(8'h81, 0);
    wait_cycles(2);
    chk("after_rst_count", 32'(rx_count), 1);
    pop_expect("after_rst", 8'h81);
    chk("after_rst_empty", 32'(rx_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout got=%0d exp=finished", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
